multiword_subtractor_seq: RTL and testbench
===========================================

// Module: multiword_subtractor_seq
// PURPOSE
//   Multi-cycle wide subtractor: computes diff = a - b - bin over 8*WORDS bits.
//   Processes one 8-bit slice per clock, LSB slice first, through one 8-bit
//   ripple-borrow subtractor stage. The borrow is registered between slices.
//   Sits upstream of the 8-bit subtractor datapath: sequences its operands
//   and chains its borrow. Uses valid/ready handshakes on input and output.
// PARAMETERS
//   WORDS  4  number of 8-bit slices; operand width W = 8*WORDS; legal range 1..16
// PORTS
//   clk        in   1  rising-edge clock
//   rst_n      in   1  asynchronous reset, active-low
//   in_valid   in   1  operands a, b and bin are valid
//   in_ready   out  1  block can accept a new operation
//   a          in   W  minuend
//   b          in   W  subtrahend
//   bin        in   1  borrow into slice 0
//   out_valid  out  1  result is valid and held
//   out_ready  in   1  downstream consumes the result
//   diff       out  W  a - b - bin, modulo 2^W
//   bout       out  1  borrow out of the MSB slice; 1 when a < b + bin (unsigned)
//   zero       out  1  1 when diff == 0
// BEHAVIOUR
//   Reset (rst_n=0, takes effect asynchronously):
//     state=IDLE; a/b shadow regs, diff, bout, zero, slice counter and borrow reg all 0.
//     in_ready=1 and out_valid=0 once reset is released.
//   FSM states: IDLE, RUN, DONE.
//     in_ready = (state==IDLE).
//     out_valid = (state==DONE).
//   IDLE: on in_valid=1 -> capture a, b and bin; cnt=0; borrow reg=bin; go to RUN.
//     Inputs are ignored in every other state.
//   RUN: each cycle, slice k=cnt is computed as {bo, d} = a[8k+7:8k] - b[8k+7:8k] - borrow.
//     d is written to diff[8k+7:8k]; the borrow reg takes bo.
//     If cnt==WORDS-1: bout <= bo, zero <= (complete diff == 0), go to DONE.
//     Otherwise cnt <= cnt+1.
//   DONE: diff, bout and zero are held stable while out_ready=0.
//     On out_ready=1 -> go to IDLE; diff, bout and zero keep their values until the next result.
//   Latency: the handshake is accepted at edge 0; out_valid goes high after edge WORDS.
//   Throughput: back-to-back operations, with out_ready tied to 1, take one every WORDS+2 cycles.
//   zero is evaluated on the full W-bit result. The final slice's d is included,
//     i.e. the result is registered combinationally before the DONE edge.
//   WORDS=1: RUN lasts a single cycle; behaviour is otherwise identical.
//   cnt width is clog2(WORDS), minimum 1 bit. cnt never exceeds WORDS-1.
//   Reset asserted in RUN or DONE aborts the operation; the result is discarded, no out_valid pulse.
//   Operands must stay unchanged only during the accept cycle; later input changes have no effect.
// TESTING (WORDS=4 unless noted)
//   1. a=0x12345678, b=0x00000001, bin=0
//      -> diff=0x12345677, bout=0, zero=0; out_valid 4 cycles after accept.
//   2. a=0x00000000, b=0x00000000, bin=1
//      -> diff=0xFFFFFFFF, bout=1, zero=0 (borrow ripples through all slices).
//   3. a=b=0xDEADBEEF, bin=0 -> diff=0, bout=0, zero=1.
//      Then a=0x00000100, b=0x00000001 -> diff=0x000000FF (cross-slice borrow).
//   4. out_ready held 0 for 5 cycles in DONE -> diff/bout/zero stable, in_ready=0,
//      new in_valid ignored; release -> in_ready=1 next cycle.
//   5. rst_n pulsed low mid-RUN (cnt=2) -> immediately IDLE with outputs 0, no out_valid.
//      The next op a=5, b=3 -> diff=2.
//   6. WORDS=1, a=0x00, b=0x01, bin=0 -> diff=0xFF, bout=1, out_valid after 1 cycle.
//      Random 1000-op compare against a W-bit reference model.

Source files
------------

// File: rtl/multiword_subtractor_seq.sv
// Sequential wide subtractor: diff = a - b - bin over 8*WORDS bits, one 8-bit slice per clock,
// LSB slice first, with the borrow registered between slices and valid/ready on both sides.
module multiword_subtractor_seq #(
    parameter int WORDS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [8*WORDS-1:0]   a,
    input  logic [8*WORDS-1:0]   b,
    input  logic                 bin,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [8*WORDS-1:0]   diff,
    output logic                 bout,
    output logic                 zero
);

    localparam int W     = 8 * WORDS;
    localparam int CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state;
    logic [W-1:0]       a_reg;
    logic [W-1:0]       b_reg;
    logic [CNT_W-1:0]   cnt;
    logic               borrow;

    logic [7:0]         a_slice;
    logic [7:0]         b_slice;
    logic [8:0]         slice_res;
    logic [W-1:0]       diff_next;
    logic               last;

    // Bit 8 of the 9-bit result is the borrow out of the slice.
    function automatic logic [8:0] sub_slice(input logic [7:0] x, input logic [7:0] y,
                                             input logic bi);
        return {1'b0, x} - {1'b0, y} - {8'd0, bi};
    endfunction

    always_comb begin
        a_slice   = '0;
        b_slice   = '0;
        diff_next = diff;
        for (int k = 0; k < WORDS; k++) begin
            if (cnt == CNT_W'(k)) begin
                a_slice = a_reg[8*k +: 8];
                b_slice = b_reg[8*k +: 8];
            end
        end
        slice_res = sub_slice(a_slice, b_slice, borrow);
        for (int k = 0; k < WORDS; k++) begin
            if (cnt == CNT_W'(k)) begin
                diff_next[8*k +: 8] = slice_res[7:0];
            end
        end
        last = (cnt == CNT_W'(WORDS - 1));
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_reg  <= '0;
            b_reg  <= '0;
            diff   <= '0;
            bout   <= 1'b0;
            zero   <= 1'b0;
            cnt    <= '0;
            borrow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg  <= a;
                        b_reg  <= b;
                        borrow <= bin;
                        cnt    <= '0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    diff   <= diff_next;
                    borrow <= slice_res[8];
                    if (last) begin
                        // zero must see the final slice, so it is taken from diff_next.
                        bout  <= slice_res[8];
                        zero  <= (diff_next == '0);
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_multiword_subtractor_seq.sv
// Directed and random checks of multiword_subtractor_seq at WORDS=4 and WORDS=1.
module tb_multiword_subtractor_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        in_valid4 = 1'b0, in_ready4, out_valid4, out_ready4 = 1'b0;
    logic [31:0] a4 = '0, b4 = '0, diff4;
    logic        bin4 = 1'b0, bout4, zero4;

    logic        in_valid1 = 1'b0, in_ready1, out_valid1, out_ready1 = 1'b0;
    logic [7:0]  a1 = '0, b1 = '0, diff1;
    logic        bin1 = 1'b0, bout1, zero1;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    multiword_subtractor_seq #(.WORDS(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a4), .b(b4), .bin(bin4), .out_valid(out_valid4), .out_ready(out_ready4),
        .diff(diff4), .bout(bout4), .zero(zero4)
    );

    multiword_subtractor_seq #(.WORDS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .bin(bin1), .out_valid(out_valid1), .out_ready(out_ready1),
        .diff(diff1), .bout(bout1), .zero(zero1)
    );

    // Drivers only: present one op, return cycles from accept edge to out_valid.
    task automatic op4(input logic [31:0] av, input logic [31:0] bv, input logic bi,
                       output int lat);
        a4 = av; b4 = bv; bin4 = bi; in_valid4 = 1'b1;
        @(posedge clk); #1;
        in_valid4 = 1'b0;
        lat = 0;
        while (!out_valid4 && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic consume4();
        out_ready4 = 1'b1;
        @(posedge clk); #1;
        out_ready4 = 1'b0;
    endtask

    task automatic op1(input logic [7:0] av, input logic [7:0] bv, input logic bi,
                       output int lat);
        a1 = av; b1 = bv; bin1 = bi; in_valid1 = 1'b1;
        @(posedge clk); #1;
        in_valid1 = 1'b0;
        lat = 0;
        while (!out_valid1 && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic consume1();
        out_ready1 = 1'b1;
        @(posedge clk); #1;
        out_ready1 = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready4 !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready4); end
        checks++;
        if (out_valid4 !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid4); end
        checks++;
        if (diff4 !== 32'h0 || bout4 !== 1'b0 || zero4 !== 1'b0) begin
            failures++; $display("FAIL reset_outputs got diff=%h bout=%b zero=%b exp=0/0/0", diff4, bout4, zero4);
        end
        checks++;
        if (in_ready1 !== 1'b1 || out_valid1 !== 1'b0) begin
            failures++; $display("FAIL reset_w1_handshake got in_ready=%b out_valid=%b exp=1/0", in_ready1, out_valid1);
        end
    endtask

    task automatic test_basic();
        int lat;
        op4(32'h12345678, 32'h00000001, 1'b0, lat);
        checks++;
        if (lat !== 4) begin failures++; $display("FAIL basic_latency got=%0d exp=4", lat); end
        checks++;
        if (diff4 !== 32'h12345677 || bout4 !== 1'b0 || zero4 !== 1'b0) begin
            failures++; $display("FAIL basic_v1 got diff=%h bout=%b zero=%b exp=12345677/0/0", diff4, bout4, zero4);
        end
        consume4();
        op4(32'h0, 32'h0, 1'b1, lat);
        checks++;
        if (diff4 !== 32'hFFFFFFFF || bout4 !== 1'b1 || zero4 !== 1'b0) begin
            failures++; $display("FAIL borrow_ripple got diff=%h bout=%b zero=%b exp=ffffffff/1/0", diff4, bout4, zero4);
        end
        consume4();
        op4(32'hDEADBEEF, 32'hDEADBEEF, 1'b0, lat);
        checks++;
        if (diff4 !== 32'h0 || bout4 !== 1'b0 || zero4 !== 1'b1) begin
            failures++; $display("FAIL equal_zero got diff=%h bout=%b zero=%b exp=0/0/1", diff4, bout4, zero4);
        end
        consume4();
        op4(32'h00000100, 32'h00000001, 1'b0, lat);
        checks++;
        if (diff4 !== 32'h000000FF || bout4 !== 1'b0 || zero4 !== 1'b0) begin
            failures++; $display("FAIL cross_slice got diff=%h bout=%b zero=%b exp=000000ff/0/0", diff4, bout4, zero4);
        end
        // Leave the result in DONE for the hold test.
    endtask

    task automatic test_hold();
        in_valid4 = 1'b1; a4 = 32'hFFFFFFFF; b4 = 32'h0; bin4 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (diff4 !== 32'h000000FF || bout4 !== 1'b0 || zero4 !== 1'b0 ||
                out_valid4 !== 1'b1 || in_ready4 !== 1'b0) begin
                failures++;
                $display("FAIL hold_cycle%0d got diff=%h bout=%b zero=%b ov=%b ir=%b exp=000000ff/0/0/1/0",
                         i, diff4, bout4, zero4, out_valid4, in_ready4);
            end
        end
        in_valid4 = 1'b0;
        consume4();
        checks++;
        if (in_ready4 !== 1'b1 || out_valid4 !== 1'b0 || diff4 !== 32'h000000FF) begin
            failures++; $display("FAIL hold_release got ir=%b ov=%b diff=%h exp=1/0/000000ff", in_ready4, out_valid4, diff4);
        end
    endtask

    task automatic test_reset_mid_run();
        int lat;
        int seen;
        a4 = 32'hAAAA5555; b4 = 32'h11112222; bin4 = 1'b0; in_valid4 = 1'b1;
        @(posedge clk); #1;
        in_valid4 = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid4 !== 1'b0 || in_ready4 !== 1'b1 || diff4 !== 32'h0) begin
            failures++; $display("FAIL reset_mid_run got ov=%b ir=%b diff=%h exp=0/1/0", out_valid4, in_ready4, diff4);
        end
        #3 rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (out_valid4) seen++;
        end
        checks++;
        if (seen !== 0) begin failures++; $display("FAIL reset_no_pulse got=%0d exp=0", seen); end
        op4(32'd5, 32'd3, 1'b0, lat);
        checks++;
        if (diff4 !== 32'd2 || bout4 !== 1'b0 || lat !== 4) begin
            failures++; $display("FAIL after_reset_op got diff=%h bout=%b lat=%0d exp=2/0/4", diff4, bout4, lat);
        end
        consume4();
    endtask

    task automatic test_back_to_back();
        int n;
        logic [31:0] res_a;
        out_ready4 = 1'b1;
        a4 = 32'h00010000; b4 = 32'h00000001; bin4 = 1'b0; in_valid4 = 1'b1;
        @(posedge clk); #1;
        a4 = 32'h80000000; b4 = 32'h80000001; bin4 = 1'b0;
        n = 0;
        res_a = 'x;
        while (!in_ready4 && n < 50) begin
            @(posedge clk); #1;
            n++;
            if (out_valid4) res_a = diff4;
        end
        @(posedge clk); #1;
        n++;
        in_valid4 = 1'b0;
        checks++;
        if (n !== 6) begin failures++; $display("FAIL b2b_interval got=%0d exp=6", n); end
        checks++;
        if (res_a !== 32'h0000FFFF) begin failures++; $display("FAIL b2b_first got=%h exp=0000ffff", res_a); end
        n = 0;
        while (!out_valid4 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (diff4 !== 32'hFFFFFFFF || bout4 !== 1'b1 || n !== 4) begin
            failures++; $display("FAIL b2b_second got diff=%h bout=%b lat=%0d exp=ffffffff/1/4", diff4, bout4, n);
        end
        @(posedge clk); #1;
        out_ready4 = 1'b0;
    endtask

    task automatic test_words1();
        int lat;
        op1(8'h00, 8'h01, 1'b0, lat);
        checks++;
        if (diff1 !== 8'hFF || bout1 !== 1'b1 || zero1 !== 1'b0 || lat !== 1) begin
            failures++; $display("FAIL w1_underflow got diff=%h bout=%b zero=%b lat=%0d exp=ff/1/0/1", diff1, bout1, zero1, lat);
        end
        consume1();
        op1(8'h06, 8'h05, 1'b1, lat);
        checks++;
        if (diff1 !== 8'h00 || bout1 !== 1'b0 || zero1 !== 1'b1) begin
            failures++; $display("FAIL w1_zero got diff=%h bout=%b zero=%b exp=00/0/1", diff1, bout1, zero1);
        end
        consume1();
    endtask

    task automatic test_random();
        int lat;
        logic [31:0] ra, rb;
        logic [7:0]  sa, sb;
        logic        rbi;
        logic [32:0] exp4;
        logic [8:0]  exp1;
        for (int i = 0; i < 300; i++) begin
            ra = $urandom; rb = $urandom; rbi = 1'($urandom_range(0, 1));
            if (i % 10 == 0) rb = ra;
            exp4 = {1'b0, ra} - {1'b0, rb} - {32'd0, rbi};
            op4(ra, rb, rbi, lat);
            checks++;
            if (diff4 !== exp4[31:0] || bout4 !== exp4[32] || zero4 !== (exp4[31:0] == 32'h0) || lat !== 4) begin
                failures++;
                $display("FAIL rand4_%0d a=%h b=%h bin=%b got diff=%h bout=%b zero=%b lat=%0d exp diff=%h bout=%b",
                         i, ra, rb, rbi, diff4, bout4, zero4, lat, exp4[31:0], exp4[32]);
            end
            consume4();
        end
        for (int i = 0; i < 1000; i++) begin
            sa = 8'($urandom); sb = 8'($urandom); rbi = 1'($urandom_range(0, 1));
            exp1 = {1'b0, sa} - {1'b0, sb} - {8'd0, rbi};
            op1(sa, sb, rbi, lat);
            checks++;
            if (diff1 !== exp1[7:0] || bout1 !== exp1[8] || zero1 !== (exp1[7:0] == 8'h0) || lat !== 1) begin
                failures++;
                $display("FAIL rand1_%0d a=%h b=%h bin=%b got diff=%h bout=%b zero=%b lat=%0d exp diff=%h bout=%b",
                         i, sa, sb, rbi, diff1, bout1, zero1, lat, exp1[7:0], exp1[8]);
            end
            consume1();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold();
        test_reset_mid_run();
        test_back_to_back();
        test_words1();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
